// File: rtl/mux2x1_pkg.sv
// mux2x1_pkg: shared select encoding and default width for the 2:1 mux cell
package mux2x1_pkg;
  localparam int WIDTH_DEF = 1;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  typedef logic mux_sel_t;
endpackage

// File: rtl/mux2x1_comb.sv
// mux2x1_comb: pure combinational 2:1 selector shared by both mux outputs
module mux2x1_comb
  import mux2x1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  mux_sel_t         Select_in,
  output logic [WIDTH-1:0] Y_out
);
  assign Y_out = (Select_in == SEL_B) ? B_in : A_in;
endmodule

// File: rtl/mux2x1_reg.sv
// mux2x1_reg: 2:1 mux with combinational and one-cycle registered outputs
// MUX2X1_LOAD_EN adds load_in gating of the register update
module mux2x1_reg
  import mux2x1_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MUX2X1_LOAD_EN
  input  logic             load_in,
`endif
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  mux_sel_t         Select_in,
  output logic [WIDTH-1:0] Y_comb_out,
  output logic [WIDTH-1:0] Y_out
);
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y;
  mux2x1_comb #(.WIDTH(WIDTH)) u_comb (
    .A_in      (A_in),
    .B_in      (B_in),
    .Select_in (Select_in),
    .Y_out     (w_y)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_y <= RESET_VAL;
`ifdef MUX2X1_LOAD_EN
    else if (load_in) r_y <= w_y;
`else
    else r_y <= w_y;
`endif
  assign Y_comb_out = w_y;
  assign Y_out      = r_y;
endmodule

// File: tb/tb_mux2x1_reg.sv
// tb_mux2x1_reg: directed and random checks of the combinational and registered mux outputs
module tb_mux2x1_reg;
  localparam int W = 1;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ld = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Sel = 1'b0;
  logic [W-1:0] Y_comb, Y;
  logic [W-1:0] exp_y = '0;
  logic [W-1:0] prev_comb;
  int           total = 0;
  int           bad = 0;
  always #10 clk = ~clk;
  mux2x1_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MUX2X1_LOAD_EN
    .load_in    (ld),
`endif
    .A_in       (A),
    .B_in       (B),
    .Select_in  (Sel),
    .Y_comb_out (Y_comb),
    .Y_out      (Y)
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset && ld) exp_y = Sel ? B : A;
    #1;
  endtask
  initial begin
    // 1: held in reset, clock edges ignored, comb path live
    A = '0; B = '1; Sel = 1'b0;
    #1;
    chk("rst_async_y", Y, '0);
    chk("rst_comb_a", Y_comb, '0);
    repeat (3) tick();
    chk("rst_hold_y", Y, '0);
    Sel = 1'b1;
    #1;
    chk("rst_comb_b", Y_comb, '1);
    chk("rst_hold_y2", Y, '0);
    // 2: release 5 ns after an edge
    tick();
    #4 reset = 1'b1;
    #1;
    chk("rel_wait_y", Y, '0);
    tick();
    chk("rel_first_y", Y, '1);
    // 3: data flip 15 ns after an edge
    #14 B = '0; A = '1;
    #1;
    chk("late_comb", Y_comb, '0);
    chk("late_y_hold", Y, '1);
    tick();
    chk("late_y_upd", Y, '0);
    // 4: toggle select on every edge
    A = '1; B = '0;
    for (int i = 0; i < 5; i++) begin
      Sel = ~Sel;
      #1 prev_comb = Y_comb;
      tick();
      chk("tog_y", Y, prev_comb);
      chk("tog_model", Y, exp_y);
    end
    // 5: async reset mid-cycle while Y=1
    Sel = 1'b0; A = '1;
    tick();
    chk("pre_rst_y", Y, '1);
    #4 reset = 1'b0;
    exp_y = '0;
    #1;
    chk("mid_rst_y", Y, '0);
    chk("mid_rst_comb", Y_comb, '1);
    #2 reset = 1'b1;
    tick();
    chk("post_rst_y", Y, '1);
`ifdef MUX2X1_LOAD_EN
    // 6: load gating
    ld = 1'b0; Sel = 1'b1; B = '0;
    tick();
    tick();
    chk("load_hold_y", Y, '1);
    ld = 1'b1;
    tick();
    chk("load_upd_y", Y, '0);
`endif
    // random traffic against the model, with occasional async reset pulses
    for (int i = 0; i < 300; i++) begin
      A = W'($urandom);
      B = W'($urandom);
      Sel = 1'($urandom);
`ifdef MUX2X1_LOAD_EN
      ld = 1'($urandom);
`endif
      #1;
      chk("rnd_comb", Y_comb, Sel ? B : A);
      if ($urandom_range(0, 19) == 0) begin
        #3 reset = 1'b0;
        exp_y = '0;
        #1;
        chk("rnd_rst_y", Y, '0);
        #2 reset = 1'b1;
      end
      tick();
      chk("rnd_y", Y, exp_y);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
